tile_ram_write_ctrl: RTL and testbench

TILE_RAM_WRITE_CTRL -- requirements
Module: tile_ram_write_ctrl

---
 rtl/tile_ram_write_ctrl.sv | 111 +++++++++++
 tb/tb_tile_ram_write_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tile_ram_write_ctrl.sv
// tile_ram_write_ctrl: sole writer of the tile RAM port, arbitrating cursor trace writes against a full-canvas clear sweep
// Ports: clk_100MHz/reset (async, active-high); clear_req_i starts a sweep from IDLE;
// trace_req_i/trace_addr_i/trace_data_i request a cursor write, acked by trace_ack_o;
// ram_we_o/ram_addr_o/ram_din_o drive the RAM write port; busy_o marks sweep writes; clear_done_o pulses after the sweep.
module tile_ram_write_ctrl #(
  parameter int MAX_X = 80,
  parameter int MAX_Y = 30,
  parameter logic [6:0] BLANK_CODE = 7'h00
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        clear_req_i,
  input  logic        trace_req_i,
  input  logic [11:0] trace_addr_i,
  input  logic [6:0]  trace_data_i,
  output logic        trace_ack_o,
  output logic        ram_we_o,
  output logic [11:0] ram_addr_o,
  output logic [6:0]  ram_din_o,
  output logic        busy_o,
  output logic        clear_done_o
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t state_q, state_d;
  logic [6:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic we_q, we_d, ack_q, ack_d, busy_q, busy_d, done_q, done_d;
  logic [11:0] addr_q, addr_d;
  logic [6:0] din_q, din_d;
  logic trace_ok, last_x, last_y;
  assign trace_ok = (trace_addr_i[6:0] < 7'(MAX_X)) && (trace_addr_i[11:7] < 5'(MAX_Y));
  assign last_x = x_q == 7'(MAX_X - 1);
  assign last_y = y_q == 5'(MAX_Y - 1);
  // Counters hold the address currently on the write port, so the sweep ends
  // when the final address has just been written.
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    we_d = 1'b0;
    ack_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    addr_d = addr_q;
    din_d = din_q;
    case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d = CLEAR;
          x_d = '0;
          y_d = '0;
          we_d = 1'b1;
          busy_d = 1'b1;
          addr_d = '0;
          din_d = BLANK_CODE;
        end else if (trace_req_i) begin
          ack_d = 1'b1;
          we_d = trace_ok;
          addr_d = trace_ok ? trace_addr_i : addr_q;
          din_d = trace_ok ? trace_data_i : din_q;
        end
      end
      CLEAR: begin
        if (last_x && last_y) begin
          state_d = DONE;
          done_d = 1'b1;
          x_d = '0;
          y_d = '0;
        end else begin
          x_d = last_x ? 7'd0 : x_q + 7'd1;
          y_d = last_x ? y_q + 5'd1 : y_q;
          we_d = 1'b1;
          busy_d = 1'b1;
          addr_d = {y_d, x_d};
          din_d = BLANK_CODE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      we_q <= 1'b0;
      ack_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      we_q <= we_d;
      ack_q <= ack_d;
      busy_q <= busy_d;
      done_q <= done_d;
      addr_q <= addr_d;
      din_q <= din_d;
    end
  end
  assign trace_ack_o = ack_q;
  assign ram_we_o = we_q;
  assign ram_addr_o = addr_q;
  assign ram_din_o = din_q;
  assign busy_o = busy_q;
  assign clear_done_o = done_q;
endmodule

// File: tb/tb_tile_ram_write_ctrl.sv
// tb_tile_ram_write_ctrl: vector table, clear-sweep sequences and randomized model check of tile_ram_write_ctrl
module tb_tile_ram_write_ctrl;
  logic clk_100MHz = 1'b0;
  logic reset = 1'b0;
  logic clear_req = 1'b0;
  logic trace_req = 1'b0;
  logic [11:0] trace_addr = '0;
  logic [6:0] trace_data = '0;
  logic trace_ack, ram_we, busy, clear_done;
  logic [11:0] ram_addr;
  logic [6:0] ram_din;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic req;
    logic [11:0] a;
    logic [6:0] d;
    logic ack;
    logic we;
    logic [11:0] ea;
    logic [6:0] ed;
  } vec_t;
  vec_t tv[9];
  int phase, idx;
  logic [11:0] m_addr;
  logic [6:0] m_din;
  logic m_ack, m_we, m_busy, m_done;
  always #5 clk_100MHz = ~clk_100MHz;
  tile_ram_write_ctrl dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .clear_req_i(clear_req),
    .trace_req_i(trace_req),
    .trace_addr_i(trace_addr),
    .trace_data_i(trace_data),
    .trace_ack_o(trace_ack),
    .ram_we_o(ram_we),
    .ram_addr_o(ram_addr),
    .ram_din_o(ram_din),
    .busy_o(busy),
    .clear_done_o(clear_done)
  );
  function automatic logic [22:0] pk(input logic a, input logic w, input logic [11:0] ad,
                                     input logic [6:0] di, input logic b, input logic dn);
    return {a, w, ad, di, b, dn};
  endfunction
  function automatic logic [22:0] obs();
    return pk(trace_ack, ram_we, ram_addr, ram_din, busy, clear_done);
  endfunction
  function automatic logic [11:0] sweep_addr(input int k);
    return {5'(k / 80), 7'(k % 80)};
  endfunction
  task automatic chk(input string name, input logic [22:0] exp);
    logic [22:0] act;
    act = obs();
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got {ack,we,addr,din,busy,done}=%h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask
  // Steps through sweep writes from..to; pulse=1 injects a stray clear_req mid-sweep, else clear_req stays high.
  task automatic run_sweep(input int from, input int to, input bit pulse);
    for (int k = from; k <= to; k++) begin
      clear_req = pulse ? (k >= 500 && k < 506) : 1'b1;
      tick();
      chk($sformatf("sweep_w%0d", k), pk(1'b0, 1'b1, sweep_addr(k), 7'h00, 1'b1, 1'b0));
    end
  endtask
  initial begin
    tv[0] = '{1'b1, {5'd10, 7'd10}, 7'h41, 1'b1, 1'b1, 12'h50A, 7'h41};
    tv[1] = '{1'b1, {5'd3, 7'd80}, 7'h22, 1'b1, 1'b0, 12'h50A, 7'h41};
    tv[2] = '{1'b1, {5'd30, 7'd0}, 7'h23, 1'b1, 1'b0, 12'h50A, 7'h41};
    tv[3] = '{1'b0, 12'hECF, 7'h7F, 1'b0, 1'b0, 12'h50A, 7'h41};
    tv[4] = '{1'b1, {5'd29, 7'd79}, 7'h7F, 1'b1, 1'b1, 12'hECF, 7'h7F};
    tv[5] = '{1'b1, {5'd0, 7'd127}, 7'h11, 1'b1, 1'b0, 12'hECF, 7'h7F};
    tv[6] = '{1'b1, {5'd31, 7'd0}, 7'h12, 1'b1, 1'b0, 12'hECF, 7'h7F};
    tv[7] = '{1'b1, {5'd0, 7'd0}, 7'h01, 1'b1, 1'b1, 12'h000, 7'h01};
    tv[8] = '{1'b1, {5'd0, 7'd1}, 7'h02, 1'b1, 1'b1, 12'h001, 7'h02};
    #2 reset = 1'b1;
    #1 chk("reset_async", '0);
    tick();
    tick();
    chk("reset_held", '0);
    @(negedge clk_100MHz) reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      trace_req = tv[i].req;
      trace_addr = tv[i].a;
      trace_data = tv[i].d;
      tick();
      chk($sformatf("vec%0d", i), pk(tv[i].ack, tv[i].we, tv[i].ea, tv[i].ed, 1'b0, 1'b0));
    end
    trace_req = 1'b1;
    trace_addr = {5'd2, 7'd5};
    trace_data = 7'h33;
    clear_req = 1'b1;
    tick();
    chk("clear_wins", pk(1'b0, 1'b1, 12'h000, 7'h00, 1'b1, 1'b0));
    run_sweep(1, 2399, 1'b1);
    clear_req = 1'b0;
    tick();
    chk("clear_done", pk(1'b0, 1'b0, 12'hECF, 7'h00, 1'b0, 1'b1));
    clear_req = 1'b1;
    tick();
    chk("done_ignores_clear", pk(1'b0, 1'b0, 12'hECF, 7'h00, 1'b0, 1'b0));
    clear_req = 1'b0;
    tick();
    chk("trace_resume", pk(1'b1, 1'b1, {5'd2, 7'd5}, 7'h33, 1'b0, 1'b0));
    trace_req = 1'b0;
    clear_req = 1'b1;
    tick();
    chk("held_clear_first", pk(1'b0, 1'b1, 12'h000, 7'h00, 1'b1, 1'b0));
    run_sweep(1, 2399, 1'b0);
    tick();
    chk("held_clear_done", pk(1'b0, 1'b0, 12'hECF, 7'h00, 1'b0, 1'b1));
    tick();
    chk("held_clear_done_exit", pk(1'b0, 1'b0, 12'hECF, 7'h00, 1'b0, 1'b0));
    tick();
    chk("held_clear_restart", pk(1'b0, 1'b1, 12'h000, 7'h00, 1'b1, 1'b0));
    run_sweep(1, 1000, 1'b0);
    clear_req = 1'b0;
    #3 reset = 1'b1;
    #1 chk("reset_mid_clear", '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_mid_hold", '0);
    end
    @(negedge clk_100MHz) reset = 1'b0;
    clear_req = 1'b1;
    tick();
    chk("restart_after_reset", pk(1'b0, 1'b1, 12'h000, 7'h00, 1'b1, 1'b0));
    clear_req = 1'b0;
    tick();
    chk("restart_second", pk(1'b0, 1'b1, 12'h001, 7'h00, 1'b1, 1'b0));
    @(negedge clk_100MHz) reset = 1'b1;
    @(negedge clk_100MHz) reset = 1'b0;
    phase = 0;
    idx = 0;
    m_addr = '0;
    m_din = '0;
    for (int n = 0; n < 6000; n++) begin
      clear_req = $urandom_range(0, 999) == 0;
      trace_req = $urandom_range(0, 9) < 7;
      trace_addr = {5'($urandom_range(0, 31)), 7'($urandom_range(0, 127))};
      trace_data = 7'($urandom);
      m_ack = 1'b0;
      m_we = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
      if (phase == 0) begin
        if (clear_req) begin
          phase = 1;
          idx = 0;
          m_we = 1'b1;
          m_busy = 1'b1;
          m_addr = sweep_addr(0);
          m_din = 7'h00;
        end else if (trace_req) begin
          m_ack = 1'b1;
          if (int'(trace_addr[6:0]) < 80 && int'(trace_addr[11:7]) < 30) begin
            m_we = 1'b1;
            m_addr = trace_addr;
            m_din = trace_data;
          end
        end
      end else if (phase == 1) begin
        if (idx == 80 * 30 - 1) begin
          phase = 2;
          m_done = 1'b1;
        end else begin
          idx++;
          m_we = 1'b1;
          m_busy = 1'b1;
          m_addr = sweep_addr(idx);
          m_din = 7'h00;
        end
      end else begin
        phase = 0;
      end
      tick();
      chk($sformatf("rand%0d", n), pk(m_ack, m_we, m_addr, m_din, m_busy, m_done));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
